// File: rtl/beat_sequencer.sv
// Record/playback sequencer for the buzzer note bus: captures (note, delta-tick) events into
// one of two slots, replays a slot on demand, and muxes live keys vs playback onto note_out.
module beat_sequencer #(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned TS_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] ascii_in,
  input  logic       rec_btn,
  input  logic       play_btn,
  input  logic       slot_sel,
  output logic [6:0] note_out,
  output logic       recording,
  output logic       playing,
  output logic [1:0] saved,
  output logic       full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = PW + 1;
  localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned EW = 7 + TS_W;

  typedef enum logic [1:0] {StIdle, StRec, StPlay} state_e;

  state_e               state_q, state_d;
  logic [DW-1:0]        div_q, div_d;
  logic [TS_W-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 slot_q, slot_d;
  logic [6:0]           prev_q;
  logic [6:0]           note_q, note_d;
  logic [1:0]           saved_q, saved_d;
  logic                 full_q, full_d;
  logic [1:0][LW-1:0]   len_q, len_d;
  logic [1:0][TS_W-1:0] tail_q, tail_d;

  logic [EW-1:0] mem [2*DEPTH];
  logic          we;
  logic [PW:0]   waddr;
  logic [EW-1:0] wdata;

  logic            tick;
  logic            change;
  logic [TS_W-1:0] cnt_inc;
  logic [PW-1:0]   ptr_nxt;
  logic [EW-1:0]   nxt_entry;
  logic [EW-1:0]   first_entry;
  logic            wr_last;
  logic            rd_last;

  assign tick        = (div_q == DW'(TICK_DIV - 1));
  assign change      = (ascii_in != prev_q);
  assign cnt_inc     = (tick && (cnt_q != '1)) ? cnt_q + TS_W'(1) : cnt_q;
  assign ptr_nxt     = ptr_q + PW'(1);
  // Asynchronous reads: next playback entry and entry 0 of the slot being started.
  assign nxt_entry   = mem[{slot_q, ptr_nxt}];
  assign first_entry = mem[{slot_sel, {PW{1'b0}}}];
  assign wr_last     = (ptr_q == PW'(DEPTH - 1));
  assign rd_last     = ({1'b0, ptr_q} == (len_q[slot_q] - LW'(1)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    slot_d  = slot_q;
    note_d  = ascii_in;
    saved_d = saved_q;
    full_d  = full_q;
    len_d   = len_q;
    tail_d  = tail_q;
    we      = 1'b0;
    waddr   = {slot_q, ptr_nxt};
    wdata   = {ascii_in, cnt_q};

    unique case (state_q)
      StIdle: begin
        if (rec_btn) begin
          slot_d           = slot_sel;
          saved_d[slot_sel] = 1'b0;
          full_d           = 1'b0;
          ptr_d            = '0;
          cnt_d            = '0;
          we               = 1'b1;
          waddr            = {slot_sel, {PW{1'b0}}};
          wdata            = {ascii_in, {TS_W{1'b0}}};
          state_d          = StRec;
        end else if (play_btn && saved_q[slot_sel]) begin
          slot_d  = slot_sel;
          ptr_d   = '0;
          cnt_d   = '0;
          note_d  = first_entry[EW-1:TS_W];
          state_d = StPlay;
        end
      end

      StRec: begin
        cnt_d = cnt_inc;
        if (change && wr_last) begin
          // Slot is full: drop this event and close the recording.
          len_d[slot_q]   = LW'(DEPTH);
          tail_d[slot_q]  = cnt_q;
          saved_d[slot_q] = 1'b1;
          full_d          = 1'b1;
          state_d         = StIdle;
        end else if (change) begin
          we    = 1'b1;
          cnt_d = TS_W'(tick);
          ptr_d = ptr_nxt;
          if (rec_btn) begin
            len_d[slot_q]   = LW'(ptr_q) + LW'(2);
            tail_d[slot_q]  = TS_W'(tick);
            saved_d[slot_q] = 1'b1;
            state_d         = StIdle;
          end
        end else if (rec_btn) begin
          len_d[slot_q]   = LW'(ptr_q) + LW'(1);
          tail_d[slot_q]  = cnt_q;
          saved_d[slot_q] = 1'b1;
          state_d         = StIdle;
        end
      end

      StPlay: begin
        note_d = note_q;
        cnt_d  = cnt_inc;
        if (play_btn) begin
          note_d  = ascii_in;
          state_d = StIdle;
        end else if (!rd_last) begin
          if (cnt_q == nxt_entry[TS_W-1:0]) begin
            note_d = nxt_entry[EW-1:TS_W];
            ptr_d  = ptr_nxt;
            cnt_d  = '0;
          end
        end else if (cnt_q == tail_q[slot_q]) begin
          note_d  = '0;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    // Divider restarts on every state entry so tick phase is identical in REC and PLAY.
    div_d = ((state_d != state_q) || tick) ? '0 : div_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      div_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      slot_q  <= 1'b0;
      prev_q  <= '0;
      note_q  <= '0;
      saved_q <= '0;
      full_q  <= 1'b0;
      len_q   <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      prev_q  <= ascii_in;
      note_q  <= note_d;
      saved_q <= saved_d;
      full_q  <= full_d;
      len_q   <= len_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign note_out  = note_q;
  assign recording = (state_q == StRec);
  assign playing   = (state_q == StPlay);
  assign saved     = saved_q;
  assign full      = full_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: event-list model of recording and a tick-arithmetic playback timeline.
module tb_beat_sequencer;

  localparam int T  = 4;
  localparam int D  = 4;
  localparam int TW = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] ascii_in;
  logic       rec_btn;
  logic       play_btn;
  logic       slot_sel;
  logic [6:0] note_out;
  logic       recording;
  logic       playing;
  logic [1:0] saved;
  logic       full;

  int checks = 0;
  int errors = 0;

  int       seq [64];
  int       sl_note [2][D];
  int       sl_delta [2][D];
  int       sl_len [2];
  int       sl_tail [2];
  bit [1:0] m_saved;
  bit       m_full;

  beat_sequencer #(.TICK_DIV(T), .DEPTH(D), .TS_W(TW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ascii_in  (ascii_in),
    .rec_btn   (rec_btn),
    .play_btn  (play_btn),
    .slot_sel  (slot_sel),
    .note_out  (note_out),
    .recording (recording),
    .playing   (playing),
    .saved     (saved),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ticks fall on cycles T-1, 2T-1, ... counted from the first cycle of a state.
  function automatic int nticks(input int a, input int b);
    int k;
    k = 0;
    for (int i = a; i < b; i++) if (i % T == T - 1) k++;
    return k;
  endfunction

  // Cycle at which the next note appears, d ticks after a note shown from cycle p.
  function automatic int advance(input int p, input int d);
    int k;
    k = 0;
    if (d == 0) return p + 1;
    for (int t = p; t < p + (d + 1) * T; t++) begin
      if (t % T == T - 1) begin
        k++;
        if (k == d) return t + 2;
      end
    end
    return -1;
  endfunction

  task automatic gen_seq(input int a0, input int n, input int rate);
    int v;
    v = a0;
    for (int c = 0; c <= n; c++) begin
      if ($urandom_range(0, rate - 1) == 0) begin
        if (v == 0 || $urandom_range(0, 2) != 0) v = 'h61 + $urandom_range(0, 5);
        else v = 0;
      end
      seq[c] = v;
    end
    seq[n] = seq[n-1];
  endtask

  task automatic check_idle_outputs(input string name, input int exp_note);
    checks++;
    if (note_out !== 7'(exp_note) || recording !== 1'b0 || playing !== 1'b0 ||
        saved !== m_saved || full !== m_full) begin
      errors++;
      $display("FAIL %s: got note=%h rec=%b play=%b saved=%b full=%b, need note=%h rec=0 play=0 saved=%b full=%b",
               name, note_out, recording, playing, saved, full, 7'(exp_note), m_saved, m_full);
    end
  endtask

  task automatic do_record(input int s, input int a0, input int n, input bit both);
    int prev, last, nev, stop, tail;
    bit ovf;
    int notes [D];
    int deltas [D];
    notes[0] = a0; deltas[0] = 0; prev = a0; last = 0; nev = 1; stop = -1; ovf = 0; tail = 0;
    for (int c = 0; c <= n && stop < 0; c++) begin
      if (seq[c] != prev) begin
        if (nev == D) begin
          ovf = 1; tail = nticks(last, c); stop = c;
        end else begin
          notes[nev] = seq[c]; deltas[nev] = nticks(last, c); nev++; last = c; prev = seq[c];
        end
      end
      if (stop < 0 && c == n) begin
        tail = nticks(last, c); stop = c;
      end
    end
    rec_btn = 1'b1; play_btn = both; slot_sel = s[0]; ascii_in = 7'(a0);
    step();
    rec_btn = 1'b0; play_btn = 1'b0;
    m_saved[s] = 1'b0; m_full = 1'b0;
    for (int c = 0; c <= stop; c++) begin
      ascii_in = 7'(seq[c]);
      rec_btn  = (c == n);
      checks++;
      if (recording !== 1'b1 || playing !== 1'b0 || saved !== m_saved || full !== 1'b0) begin
        errors++;
        $display("FAIL rec_active c=%0d: got rec=%b play=%b saved=%b full=%b, need rec=1 play=0 saved=%b full=0",
                 c, recording, playing, saved, full, m_saved);
      end
      step();
    end
    rec_btn = 1'b0;
    m_saved[s] = 1'b1; m_full = ovf;
    for (int i = 0; i < nev; i++) begin
      sl_note[s][i] = notes[i]; sl_delta[s][i] = deltas[i];
    end
    sl_len[s] = ovf ? D : nev;
    sl_tail[s] = tail;
    check_idle_outputs("rec_stop", seq[stop]);
  endtask

  task automatic do_play(input int s, input int abort_at);
    int times [D];
    int pend, live, en;
    bit ep;
    times[0] = 0;
    for (int i = 1; i < sl_len[s]; i++) times[i] = advance(times[i-1], sl_delta[s][i]);
    pend = advance(times[sl_len[s]-1], sl_tail[s]);
    live = $urandom_range(1, 127);
    play_btn = 1'b1; slot_sel = s[0]; ascii_in = 7'(live);
    step();
    play_btn = 1'b0;
    for (int n = 0; n <= pend; n++) begin
      en = 0;
      for (int i = 0; i < sl_len[s]; i++) if (times[i] <= n) en = sl_note[s][i];
      ep = (n < pend);
      if (!ep) en = 0;
      checks++;
      if (note_out !== 7'(en) || playing !== ep || recording !== 1'b0) begin
        errors++;
        $display("FAIL play c=%0d slot=%0d: got note=%h play=%b rec=%b, need note=%h play=%b rec=0",
                 n, s, note_out, playing, recording, 7'(en), ep);
      end
      if (n == abort_at) begin
        live = $urandom_range(1, 127);
        play_btn = 1'b1; ascii_in = 7'(live);
        step();
        play_btn = 1'b0;
        check_idle_outputs("play_abort", live);
        return;
      end
      step();
    end
    check_idle_outputs("play_end_live", live);
  endtask

  task automatic test_reset();
    reset = 1'b1; ascii_in = 7'h55; rec_btn = 1'b0; play_btn = 1'b0; slot_sel = 1'b0;
    step();
    step();
    reset = 1'b0; m_saved = 2'b00; m_full = 1'b0;
    ascii_in = 7'h00;
    check_idle_outputs("reset_state", 0);
    step();
    ascii_in = 7'h61;
    step();
    check_idle_outputs("live_delay", 'h61);
  endtask

  task automatic test_directed();
    for (int c = 0; c <= 36; c++) seq[c] = (c >= 3 * T && c < 5 * T) ? 'h61 : 0;
    do_record(0, 0, 36, 1'b0);
    do_play(0, -1);
  endtask

  task automatic test_unsaved_and_collision();
    play_btn = 1'b1; slot_sel = 1'b1;
    step();
    play_btn = 1'b0;
    check_idle_outputs("unsaved_play", ascii_in);
    step();
    check_idle_outputs("unsaved_play_hold", ascii_in);
    gen_seq('h62, 24, 4);
    do_record(1, 'h62, 24, 1'b1);
    do_play(1, -1);
  endtask

  task automatic test_random();
    int s, a0, n;
    for (int it = 0; it < 5; it++) begin
      s  = $urandom_range(0, 1);
      a0 = ($urandom_range(0, 1) == 0) ? 0 : 'h61 + $urandom_range(0, 5);
      n  = $urandom_range(16, 40);
      gen_seq(a0, n, 5);
      do_record(s, a0, n, 1'b0);
      do_play(s, -1);
    end
  endtask

  task automatic test_overflow();
    int v;
    v = 0;
    for (int c = 0; c <= 30; c++) begin
      if (c % 3 == 2 && c < 18) v = (v == 0) ? 'h61 + c / 3 : 0;
      seq[c] = v;
    end
    do_record(1, 0, 30, 1'b0);
    do_play(1, -1);
  endtask

  task automatic test_rerecord_and_abort();
    for (int c = 0; c <= 36; c++) seq[c] = (c >= 3 * T && c < 5 * T) ? 'h64 : 'h63;
    do_record(0, 'h63, 36, 1'b0);
    do_play(0, 10);
  endtask

  task automatic test_reset_mid();
    rec_btn = 1'b1; slot_sel = 1'b0; ascii_in = 7'h61;
    step();
    rec_btn = 1'b0;
    step();
    ascii_in = 7'h62;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; m_saved = 2'b00; m_full = 1'b0;
    check_idle_outputs("reset_in_rec", 0);
    gen_seq('h65, 20, 4);
    do_record(1, 'h65, 20, 1'b0);
    play_btn = 1'b1; slot_sel = 1'b1;
    step();
    play_btn = 1'b0;
    step();
    step();
    ascii_in = 7'h66;
    reset = 1'b1;
    step();
    reset = 1'b0; m_saved = 2'b00; m_full = 1'b0;
    check_idle_outputs("reset_in_play", 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_unsaved_and_collision();
    test_random();
    test_overflow();
    test_rerecord_and_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/beat_sequencer.md
Name: beat_sequencer

Overview:
Record/playback controller for the beat recorder's buzzer datapath. Captures changes on the decoded keyboard ascii stream as (note, delta-time) events into one of two save slots. Replays a saved slot on demand. Arbitrates the single note bus that drives the rate_divider buzzers: live free-play ascii, or the playback stream while a slot is playing.

Parameters:
TICK_DIV, 500000, clk cycles per timing tick (10 ms at 50 MHz)
DEPTH, 64, events per slot (power of 2)
TS_W, 16, delta-time field width in ticks

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
reset  in  1  synchronous, active-high reset
ascii_in  in  7  live key code from read_keyboard; 0 = no key
rec_btn  in  1  single-cycle pulse; start/stop recording
play_btn  in  1  single-cycle pulse; start/abort playback
slot_sel  in  1  target slot for record/play, sampled on the button pulse
note_out  out  7  note code to buzzer rate dividers
recording  out  1  high in REC
playing  out  1  high in PLAY
saved  out  2  per-slot valid-recording flags (LEDG)
full  out  1  sticky: last recording ended on DEPTH overflow

Behaviour:
- Reset values: state IDLE; note_out = 0; recording = playing = full = 0; saved = 2'b00; tick divider, delta counter and pointers = 0. Memory contents are don't-care.
- Tick: free-running divider pulses tick for 1 cycle every TICK_DIV cycles. The divider restarts at 0 on every state entry.
- Arbitration: note_out is registered. In PLAY it carries the playback note. In IDLE/REC it is ascii_in delayed 1 cycle.
- IDLE:
  - rec_btn: latch slot, clear saved[slot] and full, wr_ptr = 0. Write entry 0 = (ascii_in, 0). Go to REC.
  - play_btn with saved[slot] = 1: go to PLAY. play_btn on an unsaved slot is ignored.
  - rec_btn and play_btn in the same cycle: rec wins.
- REC:
  - Delta counter increments on each tick and saturates at 2^TS_W-1.
  - When ascii_in differs from the previous cycle's ascii_in: write (ascii_in, delta) at wr_ptr+1, clear delta, increment wr_ptr. The counter restarts at 0, or at 1 if tick fires in the same cycle.
  - rec_btn: store tail[slot] = delta and len[slot] = wr_ptr+1, set saved[slot], go to IDLE. A change and rec_btn in the same cycle: the change is written first, then the stop completes.
  - Write when wr_ptr+1 = DEPTH: the event is dropped, len = DEPTH, tail = delta, saved set, full set, go to IDLE.
  - play_btn is ignored.
- PLAY:
  - Entry cycle: rd_ptr = 0, note_out = entry0.note on the first PLAY clock edge, wait counter = 0.
  - On each tick, wait counter increments. When it equals entry[rd_ptr+1].delta, note_out updates to that note on the following edge (1 cycle after the tick), rd_ptr increments and the counter clears. An entry with delta 0 is presented on the cycle after the previous one.
  - After the last entry (rd_ptr = len-1), count tail ticks. Then note_out = 0, playing = 0, go to IDLE.
  - play_btn aborts to IDLE; note_out returns to live on the next edge.
  - rec_btn is ignored.
- Memory: 2×DEPTH × (7+TS_W) entries, slot is the address MSB. The read may be registered, but note_out timing above is mandatory; prefetch the next entry.
- Recording a slot never disturbs the other slot's data or saved bit.
- Reset mid-REC/PLAY: immediate return to reset values; both slots are invalidated.

Test Plan:
- Reset, then ascii_in = 7'h61 → note_out = 7'h61 one cycle later; recording = playing = 0; saved = 00.
- TICK_DIV = 4: rec_btn with slot 0 and ascii = 0. Set ascii 7'h61 at tick 3 and 0 at tick 5, then rec_btn at tick 9 → saved = 01, len = 3, tail = 4. play_btn with slot 0 → note_out 0, 61 after 3 ticks, 0 after 2 more, then IDLE after 4 ticks; playing drops.
- play_btn with slot 1 unsaved → stays IDLE, playing = 0. rec_btn and play_btn in the same cycle → recording = 1.
- DEPTH = 4: record 6 key changes → auto-stop after the 3rd change, full = 1, saved[slot] = 1, len = 4; playback emits exactly 4 notes.
- Mid-playback play_btn → playing = 0 next cycle, note_out follows live ascii_in. Re-record slot 0 → saved[0] clears at start, saved[1] is unchanged.
- Assert reset during REC and during PLAY → all outputs at reset values the next cycle, saved = 00.
